// File: rtl/curve_arbiter.sv
// Round-robin arbiter sharing one curve25519 scalar-multiply core between two requesters.
// Grants latch operands, launch the core, and return done/error pulses to the owner.
module curve_arbiter #(
    parameter int KEY_SIZE       = 255,
    parameter int TIMEOUT_CYCLES = 2000000,
    parameter int LOG_TIMEOUT    = 21
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic [1:0]          req,
    input  logic [KEY_SIZE-1:0] n0,
    input  logic [KEY_SIZE-1:0] n1,
    input  logic [KEY_SIZE-1:0] q0,
    input  logic [KEY_SIZE-1:0] q1,
    output logic [1:0]          done,
    output logic [1:0]          error,
    output logic [KEY_SIZE-1:0] result,
    output logic                busy,
    output logic                owner,
    output logic                core_start,
    output logic [KEY_SIZE-1:0] core_n,
    output logic [KEY_SIZE-1:0] core_q,
    input  logic                core_done,
    input  logic [KEY_SIZE-1:0] core_out
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        BUSY,
        DONE,
        ERR
    } state_t;

    localparam logic [LOG_TIMEOUT-1:0] COUNT_LAST = LOG_TIMEOUT'(TIMEOUT_CYCLES - 1);

    state_t                 state;
    state_t                 state_next;
    logic                   last_winner;
    logic [LOG_TIMEOUT-1:0] count;
    logic                   grant_valid;
    logic                   grant_idx;
    logic                   timeout_hit;

    // On a tie the requester that did not win last time is served.
    always_comb begin
        grant_valid = |req;
        grant_idx   = 1'b0;
        case (req)
            2'b10:   grant_idx = 1'b1;
            2'b11:   grant_idx = ~last_winner;
            default: grant_idx = 1'b0;
        endcase
    end

    assign timeout_hit = (count == COUNT_LAST);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (grant_valid) state_next = START;
            START:   state_next = BUSY;
            BUSY: begin
                // A completion on the final count still counts as a success.
                if (core_done)        state_next = DONE;
                else if (timeout_hit) state_next = ERR;
            end
            DONE:    state_next = IDLE;
            ERR:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        done       = 2'b00;
        error      = 2'b00;
        core_start = (state == START);
        busy       = (state != IDLE);
        if (state == DONE) done[owner]  = 1'b1;
        if (state == ERR)  error[owner] = 1'b1;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Operands are captured only at grant, so requester-side changes cannot reach the core mid-run.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            owner  <= 1'b0;
            core_n <= '0;
            core_q <= '0;
        end else if (state == IDLE && grant_valid) begin
            owner  <= grant_idx;
            core_n <= grant_idx ? n1 : n0;
            core_q <= grant_idx ? q1 : q0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (state == START) begin
            count <= '0;
        end else if (state == BUSY) begin
            count <= count + LOG_TIMEOUT'(1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            result <= '0;
        end else if (state == BUSY && core_done) begin
            result <= core_out;
        end
    end

    // Starts at 1 so requester 0 takes the first tie after reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            last_winner <= 1'b1;
        end else if (state == DONE || state == ERR) begin
            last_winner <= owner;
        end
    end

endmodule

// File: doc/curve_arbiter.md
CURVE_ARBITER -- requirements
Module: curve_arbiter

Interface
REQ-001 Parameter KEY_SIZE, default 255, width of scalar, point and result buses.
REQ-002 Parameter TIMEOUT_CYCLES, default 2000000, max BUSY cycles before abort; must be >= 2.
REQ-003 Parameter LOG_TIMEOUT, default 21, width of timeout counter; 2^LOG_TIMEOUT SHALL exceed TIMEOUT_CYCLES.
REQ-004 clock  input  1  sole clock, all state on posedge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 req  input  2  per-requester level request, held until done[i] or error[i].
REQ-007 n0, n1  input  KEY_SIZE  scalar from requester 0/1.
REQ-008 q0, q1  input  KEY_SIZE  point from requester 0/1.
REQ-009 done  output  2  one-cycle pulse to owner when result valid.
REQ-010 error  output  2  one-cycle pulse to owner on timeout.
REQ-011 result  output  KEY_SIZE  last completed core output, valid from done pulse until next completion.
REQ-012 busy  output  1  high in any state other than IDLE.
REQ-013 owner  output  1  index of current/last granted requester.
REQ-014 core_start  output  1  one-cycle start pulse to shared curve25519 core.
REQ-015 core_n, core_q  output  KEY_SIZE  registered operands to core.
REQ-016 core_done  input  1  core completion flag.
REQ-017 core_out  input  KEY_SIZE  core result.

Function
REQ-018 States SHALL be IDLE, START, BUSY, DONE, ERR.
REQ-019 IDLE: if any req bit high, select winner, latch that requester's n/q into core_n/core_q, set owner, go START; else stay.
REQ-020 Arbitration SHALL be round-robin: single request wins; both high -> requester other than last_winner wins.
REQ-021 START: core_start=1 for exactly this cycle, clear timeout counter, go BUSY.
REQ-022 core_done SHALL be ignored in every state except BUSY.
REQ-023 BUSY: counter increments each cycle; core_done=1 -> latch core_out into result, go DONE.
REQ-024 BUSY: counter reaches TIMEOUT_CYCLES-1 with core_done=0 -> go ERR, result unchanged.
REQ-025 core_done and timeout in same cycle -> core_done wins (DONE path).
REQ-026 DONE: done[owner]=1, last_winner<=owner, go IDLE.
REQ-027 ERR: error[owner]=1, last_winner<=owner, go IDLE.
REQ-028 Latency: winner request in IDLE at edge k -> core_start high in cycle k+1; done pulse one cycle after core_done sampled.
REQ-029 Requesters drop req on cycle after done/error; req still high in IDLE is a new request.
REQ-030 req changes or operand changes after latch SHALL NOT affect core_n/core_q until next grant.
REQ-031 Dropping req mid-operation SHALL NOT abort; completion pulse still issued to owner.
REQ-032 done and error SHALL never be asserted together, and at most one bit of each at once.

Reset
REQ-033 reset_n low SHALL immediately force state IDLE, done=0, error=0, core_start=0, busy=0, owner=0, counter=0.
REQ-034 Reset SHALL clear result, core_n, core_q to 0 and set last_winner=1 so requester 0 wins first tie.
REQ-035 Reset mid-BUSY abandons operation with no done/error pulse; core_done after release ignored until next START.

Verification
REQ-036 Single request: req=01, n0=5, q0=9, core model done 3 cycles after start, out=0x33 -> core_start one cycle, core_n=5, core_q=9, done=01 one cycle, result=0x33, owner=0.
REQ-037 Tie after reset: req=11 -> req0 served first, then req1 (req1 held) with n1/q1 latched; next tie -> req0.
REQ-038 Timeout: TIMEOUT_CYCLES=16, core never completes -> error[owner] pulses 16 cycles after BUSY entry, result unchanged, busy drops.
REQ-039 Simultaneous core_done and timeout on final count -> done pulse, no error, result=core_out.
REQ-040 Reset asserted two cycles into BUSY -> all outputs 0 within same cycle, stray core_done after release produces no done pulse.
REQ-041 Operand change: n0 altered after grant -> core_n keeps granted value through DONE.
